// File: rtl/memory_cell_reader.sv
// memory_cell_reader: read-side sequencer for a memory_cell (port b).
// It drives addr_b, captures the registered read data into a 2-entry FIFO and
// re-emits the words as a valid/ready stream with full backpressure.
// Optional feature macro: MEMORY_CELL_READER_REVERSE_EN adds i_rev, which
// streams the burst in descending address order.
module memory_cell_reader #(
  parameter int ADDR  = 12,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [ADDR-1:0]  i_base,
  input  logic [ADDR-1:0]  i_len,
`ifdef MEMORY_CELL_READER_REVERSE_EN
  input  logic             i_rev,
`endif
  output logic [ADDR-1:0]  o_addr_b,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR-1:0] ONE = ADDR'(1);

  state_t           state_q, state_d;
  logic [ADDR-1:0]  base_q, len_q, issued_q, issued_d, addr_q, issue_addr;
  logic             rev_q, rev_in;
  logic             inflight_q, zero_done_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             start_ok, issue, pop, push, drain_done;
  logic [2:0]       occ;

`ifdef MEMORY_CELL_READER_REVERSE_EN
  assign rev_in = i_rev;
`else
  assign rev_in = 1'b0;
`endif

  assign start_ok = i_start & (state_q == IDLE);
  assign pop      = o_valid & i_ready;
  // Data of a read issued last cycle is on i_rd_data now; capture only those.
  assign push     = inflight_q;
  // Occupancy the FIFO would have after this cycle if no new read were issued.
  assign occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Next-state, read issue and address selection.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        // Read 0 goes out in the start cycle so the first word is valid two
        // cycles after i_start.
        if (start_ok && (i_len != '0)) begin
          issue      = 1'b1;
          issue_addr = rev_in ? (i_base + i_len - ONE) : i_base;
          issued_d   = ONE;
          state_d    = (i_len == ONE) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (occ <= 3'd1) begin
          issue      = 1'b1;
          issue_addr = rev_q ? (base_q + len_q - ONE - issued_q) : (base_q + issued_q);
          issued_d   = issued_q + ONE;
          if (issued_q == len_q - ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((cnt_q == 2'd0) && !inflight_q) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The address port holds its last value whenever no read is issued.
  assign o_addr_b = issue ? issue_addr : addr_q;
  assign o_valid  = (cnt_q != 2'd0);
  assign o_data   = head_q;
  assign o_done   = drain_done | zero_done_q;
  assign o_busy   = (state_q != IDLE) & ~drain_done;

  // Control state, burst parameters and read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rev_q       <= 1'b0;
      issued_q    <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      addr_q      <= o_addr_b;
      inflight_q  <= issue;
      zero_done_q <= start_ok & (i_len == '0);
      if (start_ok) begin
        base_q <= i_base;
        len_q  <= i_len;
        rev_q  <= rev_in;
      end
    end
  end

  // Two-entry output FIFO; head_q is the stream word and only moves on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (push && pop) begin
      if (cnt_q == 2'd2) begin
        head_q <= tail_q;
        tail_q <= i_rd_data;
      end else begin
        head_q <= i_rd_data;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) head_q <= i_rd_data;
      else               tail_q <= i_rd_data;
      cnt_q <= cnt_q + 2'd1;
    end else if (pop) begin
      head_q <= tail_q;
      cnt_q  <= cnt_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_memory_cell_reader.sv
// Bench for memory_cell_reader: behavioural memory plus an address-arithmetic
// reference of the expected word order; randomized bursts and backpressure.
module tb_memory_cell_reader;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_start = 1'b0, i_ready = 1'b0, rev = 1'b0;
  logic [11:0] i_base = '0, i_len = '0, o_addr_b;
  logic [31:0] i_rd_data, o_data;
  logic        o_valid, o_busy, o_done;

  logic [31:0] mem [0:4095];

  memory_cell_reader #(.ADDR(12), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base(i_base), .i_len(i_len),
`ifdef MEMORY_CELL_READER_REVERSE_EN
    .i_rev(rev),
`endif
    .o_addr_b(o_addr_b), .i_rd_data(i_rd_data), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // memory_cell port b: registered read, one cycle of latency.
  always @(posedge clk) i_rd_data <= mem[o_addr_b];

  int n_cmp = 0, n_err = 0;

  logic [31:0] got_q[$], exp_q[$];
  int first_v, done_cyc, last_hs, ndone, unstable;
  bit busy_bad, timeout;

  task automatic fill_linear();
    for (int a = 0; a < 4096; a++) mem[a] = 32'(a + 'h100);
  endtask

  // Expected stream: word k comes from (base+k) or (base+len-1-k) mod 4096.
  task automatic build_exp(input int b, input int l, input bit r);
    exp_q.delete();
    for (int k = 0; k < l; k++) exp_q.push_back(mem[r ? (b + l - 1 - k) % 4096 : (b + k) % 4096]);
  endtask

  // Runs one burst and records observations; cycle 0 is the i_start cycle.
  // rmode: 0 ready high, 1 pattern 1,0,0,1,0,1, 2 random. ign: cycle of an
  // extra i_start pulse with junk parameters (-1 = none).
  task automatic do_burst(input int b, input int l, input bit r, input int rmode, input int ign);
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    bit seen_done = 0, prev_hold = 0, exp_busy;
    logic [31:0] prev_data = '0;
    int post = 0;
    got_q.delete();
    first_v = -1; done_cyc = -1; last_hs = -1; ndone = 0; unstable = 0;
    busy_bad = 0; timeout = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        i_start = 1; i_base = 12'(b); i_len = 12'(l); rev = r;
      end else if (c == ign) begin
        i_start = 1; i_base = 12'(b + 1000); i_len = 12'd7; rev = ~r;
      end else begin
        i_start = 0;
      end
      i_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[c % 6] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (o_done) begin ndone++; done_cyc = c; seen_done = 1; end
      exp_busy = (l != 0) && (c >= 1) && !seen_done;
      if (o_busy !== exp_busy) busy_bad = 1;
      if (prev_hold && (!o_valid || o_data !== prev_data)) unstable++;
      if (o_valid && first_v < 0) first_v = c;
      if (o_valid && i_ready) begin got_q.push_back(o_data); last_hs = c; end
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
      if (seen_done) begin
        timeout = 0;
        post++;
        if (post > 4) break;
      end
    end
    @(posedge clk); #1;
    i_start = 0; i_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (o_addr_b !== 12'h0) begin n_err++; $display("FAIL reset_addr got=%h want=0", o_addr_b); end
    n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h want=0", o_data); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", o_done); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
  endtask

  task automatic test_basic();
    fill_linear();
    build_exp(5, 4, 0);
    do_burst(5, 4, 0, 0, -1);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL basic_count got=%0d want=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL basic_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (first_v != 2) begin n_err++; $display("FAIL basic_latency got=%0d want=2", first_v); end
    n_cmp++; if (last_hs != 5) begin n_err++; $display("FAIL basic_last_word_cycle got=%0d want=5", last_hs); end
    n_cmp++; if (ndone != 1 || done_cyc != 6) begin n_err++; $display("FAIL basic_done got=%0d@%0d want=1@6", ndone, done_cyc); end
    n_cmp++; if (busy_bad || timeout) begin n_err++; $display("FAIL basic_busy got=%b/%b want=0/0", busy_bad, timeout); end
  endtask

  task automatic test_backpressure();
    fill_linear();
    build_exp(5, 4, 0);
    do_burst(5, 4, 0, 1, -1);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL bp_count got=%0d want=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL bp_stable got=%0d want=0", unstable); end
    n_cmp++; if (ndone != 1 || done_cyc != last_hs + 1) begin n_err++; $display("FAIL bp_done got=%0d@%0d want=1@%0d", ndone, done_cyc, last_hs + 1); end
    n_cmp++; if (busy_bad || timeout) begin n_err++; $display("FAIL bp_busy got=%b/%b want=0/0", busy_bad, timeout); end
  endtask

  task automatic test_zero_len();
    do_burst(9, 0, 0, 0, -1);
    n_cmp++; if (ndone != 1 || done_cyc != 1) begin n_err++; $display("FAIL zero_done got=%0d@%0d want=1@1", ndone, done_cyc); end
    n_cmp++; if (first_v != -1) begin n_err++; $display("FAIL zero_valid got=%0d want=-1", first_v); end
    n_cmp++; if (busy_bad) begin n_err++; $display("FAIL zero_busy got=%b want=0", busy_bad); end
  endtask

  task automatic test_wrap();
    fill_linear();
    build_exp(12'hFFE, 4, 0);
    do_burst(12'hFFE, 4, 0, 0, -1);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL wrap_count got=%0d want=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL wrap_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL wrap_done got=%0d want=1", ndone); end
  endtask

  task automatic test_reset_mid();
    int hs = 0, dn = 0;
    fill_linear();
    @(posedge clk); #1;
    i_start = 1; i_base = 12'd0; i_len = 12'd8; rev = 0; i_ready = 1;
    for (int c = 0; c < 30 && hs < 2; c++) begin
      @(negedge clk);
      if (o_valid && i_ready) hs++;
      @(posedge clk); #1; i_start = 0;
    end
    n_cmp++; if (hs != 2) begin n_err++; $display("FAIL rstmid_words got=%0d want=2", hs); end
    @(negedge clk); #2;
    rst = 1; #1;
    n_cmp++; if (o_valid !== 0 || o_busy !== 0 || o_done !== 0) begin n_err++; $display("FAIL rstmid_ctrl got=%b%b%b want=000", o_valid, o_busy, o_done); end
    n_cmp++; if (o_addr_b !== 0 || o_data !== 0) begin n_err++; $display("FAIL rstmid_bus got=%h/%h want=0/0", o_addr_b, o_data); end
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (o_done) dn++; end
    rst = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (o_done || o_valid) dn++; end
    n_cmp++; if (dn != 0) begin n_err++; $display("FAIL rstmid_quiet got=%0d want=0", dn); end
    build_exp(0, 2, 0);
    do_burst(0, 2, 0, 0, -1);
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL rstmid_after_count got=%0d want=2", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 2; k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rstmid_after_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    fill_linear();
    build_exp(20, 5, 0);
    do_burst(20, 5, 0, 0, 2);
    n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL b2b_count got=%0d want=5", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 5; k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL b2b_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (ndone != 1 || busy_bad) begin n_err++; $display("FAIL b2b_done got=%0d/%b want=1/0", ndone, busy_bad); end
  endtask

`ifdef MEMORY_CELL_READER_REVERSE_EN
  task automatic test_reverse();
    fill_linear();
    build_exp(5, 4, 1);
    do_burst(5, 4, 1, 0, 2);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL rev_count got=%0d want=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rev_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (first_v != 2 || ndone != 1 || done_cyc != 6) begin n_err++; $display("FAIL rev_timing got=%0d/%0d@%0d want=2/1@6", first_v, ndone, done_cyc); end
  endtask
`endif

  task automatic test_random();
    int b, l, ign;
    bit r;
    for (int a = 0; a < 4096; a++) mem[a] = $urandom;
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(0, 4095);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
`ifdef MEMORY_CELL_READER_REVERSE_EN
      r = 1'($urandom_range(0, 1));
`else
      r = 0;
`endif
      ign = (l == 0) ? -1 : $urandom_range(1, 2);
      build_exp(b, l, r);
      do_burst(b, l, r, 2, ign);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_count got=%0d want=%0d", t, got_q.size(), exp_q.size()); end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        n_cmp++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rnd%0d_word%0d got=%h want=%h", t, k, got_q[k], exp_q[k]); end
      end
      n_cmp++; if (ndone != 1 || unstable != 0 || busy_bad || timeout) begin
        n_err++; $display("FAIL rnd%0d_ctrl got=done%0d/unst%0d/busy%b/to%b want=1/0/0/0", t, ndone, unstable, busy_bad, timeout);
      end
      if (l != 0) begin
        n_cmp++; if (done_cyc != last_hs + 1) begin n_err++; $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", t, done_cyc, last_hs + 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef MEMORY_CELL_READER_REVERSE_EN
    test_reverse();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
